// File: rtl/wb_tracker_queued_if.sv
// Trace element types and the EX-tracker / trace-sink bundle of the queued write-back tracker.
// Time fields are 32 bits wide; the tracker truncates or zero-extends its counter to fit them.

typedef struct packed {
    logic [31:0] time_start;
    logic [31:0] time_end;
} trace_span_t;

typedef struct packed {
    logic        pass_through;
    logic [31:0] insn_id;
    trace_span_t wb;
    trace_span_t mem_access_req;
    trace_span_t mem_access_res;
} trace_output;

interface wb_tracker_queued_if;
    logic        ex_data_ready;
    trace_output ex_data_i;
    logic        ex_accept_o;
    logic        data_rvalid_i;
    logic        wb_ready;
    trace_output wb_data_o;
    logic        wb_valid_o;
    logic        queue_full_o;
    logic        queue_empty_o;
    logic        overflow_o;

    modport master (
        output ex_data_ready, ex_data_i, data_rvalid_i, wb_ready,
        input  ex_accept_o, wb_data_o, wb_valid_o, queue_full_o, queue_empty_o, overflow_o
    );

    modport slave (
        input  ex_data_ready, ex_data_i, data_rvalid_i, wb_ready,
        output ex_accept_o, wb_data_o, wb_valid_o, queue_full_o, queue_empty_o, overflow_o
    );
endinterface

// File: rtl/wb_tracker_queued.sv
// Queued write-back tracker: buffers EX elements in order and timestamps the head's WB / memory phases.
// Optional WB_TRACKER_STALL_COUNT_EN adds stall_cycles_o (cycles spent waiting for rvalid).

module wb_tracker_queued #(
    parameter int unsigned QUEUE_DEPTH   = 4,
    parameter int unsigned COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [COUNTER_WIDTH-1:0] counter,
`ifdef WB_TRACKER_STALL_COUNT_EN
    output logic [COUNTER_WIDTH-1:0] stall_cycles_o,
`endif
    wb_tracker_queued_if.slave       bus
);

    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [1:0] HeadIdle       = 2'd0;
    localparam logic [1:0] HeadCheck      = 2'd1;
    localparam logic [1:0] HeadWaitRvalid = 2'd2;

    trace_output         mem_q [QUEUE_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]     count_q, count_d;
    logic [CntW-1:0]     bank_q, bank_d;
    logic [1:0]          state_q, state_d;
    trace_output         work_q, work_d;
    trace_output         wb_data_q, wb_data_d;
    logic                wb_valid_q;
    logic                overflow_q;

    logic                full, empty, enq, deq, emit, consume;
    logic [31:0]         stamp;
    trace_output         head;

    assign full  = (count_q == CntW'(QUEUE_DEPTH));
    assign empty = (count_q == '0);
    assign enq   = bus.ex_data_ready && !full;
    assign head  = mem_q[rd_ptr_q];
    assign stamp = 32'(counter);

    assign bus.ex_accept_o   = !full;
    assign bus.queue_full_o  = full;
    assign bus.queue_empty_o = empty;
    assign bus.overflow_o    = overflow_q;
    assign bus.wb_data_o     = wb_data_q;
    assign bus.wb_valid_o    = wb_valid_q;

    // Head FSM: the element stays in the queue until emitted; work_q carries its timestamps.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        emit    = 1'b0;
        deq     = 1'b0;
        consume = 1'b0;
        unique case (state_q)
            HeadIdle: begin
                if (!empty) begin
                    work_d = head;
                    if (head.pass_through) begin
                        emit = 1'b1;
                        deq  = 1'b1;
                    end else begin
                        state_d = HeadCheck;
                    end
                end
            end
            HeadCheck: begin
                work_d.wb.time_start = stamp;
                if (bus.wb_ready) begin
                    work_d.wb.time_end = stamp;
                    emit    = 1'b1;
                    deq     = 1'b1;
                    state_d = HeadIdle;
                end else if (work_q.mem_access_req.time_start != '0 &&
                             work_q.mem_access_req.time_end != '0) begin
                    work_d.mem_access_res.time_start = stamp;
                    if (bank_q != '0 || bus.data_rvalid_i) begin
                        work_d.mem_access_res.time_end = stamp;
                        work_d.wb.time_end             = stamp;
                        emit    = 1'b1;
                        deq     = 1'b1;
                        consume = 1'b1;
                        state_d = HeadIdle;
                    end else begin
                        state_d = HeadWaitRvalid;
                    end
                end
            end
            HeadWaitRvalid: begin
                if (bus.data_rvalid_i) begin
                    work_d.mem_access_res.time_end = stamp;
                    work_d.wb.time_end             = stamp;
                    emit    = 1'b1;
                    deq     = 1'b1;
                    consume = 1'b1;
                    state_d = HeadIdle;
                end
            end
            default: state_d = HeadIdle;
        endcase
    end

    // A consumed rvalid that arrived this cycle never touches the bank.
    always_comb begin
        bank_d = bank_q;
        if (bus.data_rvalid_i && !consume) begin
            if (bank_q != CntW'(QUEUE_DEPTH)) bank_d = bank_q + 1'b1;
        end else if (consume && !bus.data_rvalid_i) begin
            bank_d = bank_q - 1'b1;
        end
    end

    always_comb begin
        count_d   = count_q + CntW'(enq) - CntW'(deq);
        wb_data_d = emit ? work_d : wb_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            bank_q     <= '0;
            state_q    <= HeadIdle;
            work_q     <= '0;
            wb_data_q  <= '0;
            wb_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            bank_q     <= bank_d;
            state_q    <= state_d;
            work_q     <= work_d;
            wb_data_q  <= wb_data_d;
            wb_valid_q <= emit;
            overflow_q <= overflow_q | (bus.ex_data_ready && full);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q] <= bus.ex_data_i;
    end

`ifdef WB_TRACKER_STALL_COUNT_EN
    logic [COUNTER_WIDTH-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state_q == HeadWaitRvalid && stall_q != '1) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_wb_tracker_queued.sv
// Bench for wb_tracker_queued: vector table of single-element transactions plus queue corner cases.
module tb_wb_tracker_queued;

    localparam int NVEC = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] counter = '0;

    wb_tracker_queued_if bus ();

`ifdef WB_TRACKER_STALL_COUNT_EN
    logic [31:0] stall_cycles;
`endif

    wb_tracker_queued #(
        .QUEUE_DEPTH   (4),
        .COUNTER_WIDTH (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .counter        (counter),
`ifdef WB_TRACKER_STALL_COUNT_EN
        .stall_cycles_o (stall_cycles),
`endif
        .bus            (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) counter <= counter + 1;

    // Offsets are relative to the counter value in the cycle the element is offered; -1 = unused.
    typedef struct {
        bit          pass;
        logic [31:0] id;
        logic [31:0] req_s;
        logic [31:0] req_e;
        int          rdy_dly;
        int          rv_dly;
        bit          pre_rv;
        int          ws;
        int          we;
        int          rs;
        int          re;
        int          emit;
    } vec_t;

    typedef struct {
        trace_output exp;
        bit          id_only;
        int          cyc;
    } sb_t;

    vec_t tbl [NVEC];
    sb_t  sb [$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.wb_valid_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_emit", 256'(bus.wb_valid_o), 256'(0));
            end else begin
                sb_t e;
                e = sb.pop_front();
                if (e.id_only) begin
                    chk("order_id", 256'(bus.wb_data_o.insn_id), 256'(e.exp.insn_id));
                end else begin
                    chk("emit_data", 256'(bus.wb_data_o), 256'(e.exp));
                    chk("emit_cycle", 256'(counter), 256'(e.cyc));
                end
            end
        end
    end

    function automatic trace_output mk(input logic pass, input logic [31:0] id,
                                       input logic [31:0] rs, input logic [31:0] re);
        trace_output d;
        d.pass_through              = pass;
        d.insn_id                   = id;
        d.wb.time_start             = 32'hAAAA_0000 + id;
        d.wb.time_end               = 32'hBBBB_0000 + id;
        d.mem_access_req.time_start = rs;
        d.mem_access_req.time_end   = re;
        d.mem_access_res.time_start = 32'hCCCC_0000 + id;
        d.mem_access_res.time_end   = 32'hDDDD_0000 + id;
        return d;
    endfunction

    task automatic wait_cyc(input int t);
        while (int'(counter) < t) @(negedge clk);
    endtask

    task automatic pulse_rv();
        bus.data_rvalid_i = 1'b1;
        @(negedge clk);
        bus.data_rvalid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 256'(sb.size()), 256'(0));
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic apply(input vec_t v);
        trace_output d;
        trace_output x;
        sb_t         s;
        int          e;
        if (v.pre_rv) pulse_rv();
        d = mk(v.pass, v.id, v.req_s, v.req_e);
        e = int'(counter);
        x = d;
        if (v.ws >= 0) x.wb.time_start = 32'(e + v.ws);
        if (v.we >= 0) x.wb.time_end = 32'(e + v.we);
        if (v.rs >= 0) x.mem_access_res.time_start = 32'(e + v.rs);
        if (v.re >= 0) x.mem_access_res.time_end = 32'(e + v.re);
        s.exp     = x;
        s.id_only = 1'b0;
        s.cyc     = e + v.emit;
        sb.push_back(s);
        bus.ex_data_ready = 1'b1;
        bus.ex_data_i     = d;
        @(negedge clk);
        bus.ex_data_ready = 1'b0;
        if (v.rdy_dly >= 0) begin
            wait_cyc(e + 2 + v.rdy_dly);
            bus.wb_ready = 1'b1;
            @(negedge clk);
            bus.wb_ready = 1'b0;
        end
        if (v.rv_dly >= 0) begin
            wait_cyc(e + 2 + v.rv_dly);
            bus.data_rvalid_i = 1'b1;
            @(negedge clk);
            bus.data_rvalid_i = 1'b0;
        end
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        sb_t s;
        //            pass id req_s req_e rdy  rv  pre  ws  we  rs  re emit
        tbl[0] = '{1'b1, 1, 0, 0, -1, -1, 1'b0, -1, -1, -1, -1, 2};
        tbl[1] = '{1'b0, 2, 0, 0,  0, -1, 1'b0,  2,  2, -1, -1, 3};
        tbl[2] = '{1'b0, 3, 0, 0,  3, -1, 1'b0,  5,  5, -1, -1, 6};
        tbl[3] = '{1'b0, 4, 5, 6, -1,  4, 1'b0,  2,  6,  2,  6, 7};
        tbl[4] = '{1'b0, 5, 5, 6, -1,  0, 1'b0,  2,  2,  2,  2, 3};
        tbl[5] = '{1'b0, 6, 7, 9, -1, -1, 1'b1,  2,  2,  2,  2, 3};
        tbl[6] = '{1'b0, 7, 5, 6, -1,  1, 1'b0,  2,  3,  2,  3, 4};
        tbl[7] = '{1'b0, 8, 5, 0,  1, -1, 1'b0,  3,  3, -1, -1, 4};
        tbl[8] = '{1'b0, 9, 5, 6,  0, -1, 1'b0,  2,  2, -1, -1, 3};
        tbl[9] = '{1'b1, 10, 5, 6, -1, -1, 1'b0, -1, -1, -1, -1, 2};

        bus.ex_data_ready = 1'b0;
        bus.ex_data_i     = '0;
        bus.data_rvalid_i = 1'b0;
        bus.wb_ready      = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_accept", 256'(bus.ex_accept_o), 256'(1));
        chk("rst_empty", 256'(bus.queue_empty_o), 256'(1));
        chk("rst_full", 256'(bus.queue_full_o), 256'(0));
        chk("rst_overflow", 256'(bus.overflow_o), 256'(0));
        chk("rst_valid", 256'(bus.wb_valid_o), 256'(0));
        chk("rst_data", 256'(bus.wb_data_o), 256'(0));
        repeat (2) @(negedge clk);

        for (int i = 0; i < NVEC; i++) apply(tbl[i]);

        // Five back-to-back offers with the head stalled: the fifth is dropped.
        for (int i = 0; i < 5; i++) begin
            bus.ex_data_ready = 1'b1;
            bus.ex_data_i     = mk(1'b0, 32'(11 + i), 32'd0, 32'd0);
            if (i < 4) begin
                s.exp     = bus.ex_data_i;
                s.id_only = 1'b1;
                s.cyc     = 0;
                sb.push_back(s);
            end
            @(negedge clk);
        end
        bus.ex_data_ready = 1'b0;
        chk("fill_full", 256'(bus.queue_full_o), 256'(1));
        chk("fill_accept", 256'(bus.ex_accept_o), 256'(0));
        chk("fill_overflow", 256'(bus.overflow_o), 256'(1));
        bus.wb_ready = 1'b1;
        drain();
        bus.wb_ready = 1'b0;
        chk("drain_empty", 256'(bus.queue_empty_o), 256'(1));
        chk("overflow_sticky", 256'(bus.overflow_o), 256'(1));

        // Reset while the head waits for rvalid with three elements queued.
        bus.ex_data_ready = 1'b1;
        bus.ex_data_i     = mk(1'b0, 32'd21, 32'd5, 32'd6);
        @(negedge clk);
        bus.ex_data_i     = mk(1'b0, 32'd22, 32'd0, 32'd0);
        @(negedge clk);
        bus.ex_data_i     = mk(1'b0, 32'd23, 32'd0, 32'd0);
        @(negedge clk);
        bus.ex_data_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_empty", 256'(bus.queue_empty_o), 256'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_empty", 256'(bus.queue_empty_o), 256'(1));
        chk("mid_rst_valid", 256'(bus.wb_valid_o), 256'(0));
        chk("mid_rst_full", 256'(bus.queue_full_o), 256'(0));
        chk("mid_rst_overflow", 256'(bus.overflow_o), 256'(0));
        repeat (3) @(negedge clk);
        apply(tbl[5]);
        apply(tbl[6]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
